// File: rtl/uart_tx.sv
// Serialises one DATA_BITS word per frame: start, data LSB first, optional parity, 1-2 stop bits.
// Latency: start bit drives txd from the edge after the tx_valid/tx_ready handshake.
// Backpressure: tx_ready is high only while idle, so upstream holds tx_valid until the line is free.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 bit_tick,
    output logic                 tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic                 period_end;

    assign period_end = (cnt == CNT_LAST);
    // Gated by rst so a handshake offered during reset is never accepted.
    assign tx_ready   = (state == IDLE) && !rst;
    assign bit_tick   = (state != IDLE) && period_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par      <= 1'b0;
        end else begin
            if (state != IDLE) begin
                cnt <= period_end ? '0 : cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (tx_valid && tx_ready) begin
                        shreg   <= tx_data;
                        // Parity is taken from the captured word, so later tx_data changes cannot leak in.
                        par     <= (^tx_data) ^ (PARITY_ODD != 0);
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (period_end) begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (period_end) begin
                        if (bit_idx == IDX_LAST) begin
                            bit_idx  <= '0;
                            stop_idx <= 1'b0;
                            if (PARITY_EN != 0) begin
                                txd   <= par;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (period_end) begin
                        txd      <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (period_end) begin
                        if (STOP_BITS == 2 && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            stop_idx <= 1'b0;
                            tx_busy  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover plain, even parity, odd parity and two-stop-bit frames.
// Outputs are sampled 1ns after each rising edge; expected slot patterns are written out by hand.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic [3:0] valid;
    logic [3:0] ready, txd, tick, busy;
    logic [1:0] sel;
    logic       m_ready, m_txd, m_tick, m_busy;

    int vectors = 0;
    int miscompares = 0;

    logic cap_txd [0:63];
    logic cap_tick[0:63];
    logic cap_busy[0:63];
    logic post_txd, post_ready, post_busy;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .txd(txd[0]), .bit_tick(tick[0]), .tx_busy(busy[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .txd(txd[1]), .bit_tick(tick[1]), .tx_busy(busy[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .txd(txd[2]), .bit_tick(tick[2]), .tx_busy(busy[2]));
    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .txd(txd[3]), .bit_tick(tick[3]), .tx_busy(busy[3]));

    always_comb begin
        m_ready = ready[sel];
        m_txd   = txd[sel];
        m_tick  = tick[sel];
        m_busy  = busy[sel];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a word on instance s and steps through the accepting edge; ok=0 if ready never rose.
    task automatic launch(input logic [1:0] s, input logic [7:0] d, input bit hold, output bit ok);
        int n;
        sel      = s;
        tx_data  = d;
        valid[s] = 1'b1;
        n = 0;
        while (m_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        ok = (m_ready === 1'b1);
        step();
        if (!hold) valid[s] = 1'b0;
    endtask

    // Records n cycles starting with the first start-bit cycle, then one idle cycle after.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_txd[i]  = m_txd;
            cap_tick[i] = m_tick;
            cap_busy[i] = m_busy;
            step();
        end
        post_txd   = m_txd;
        post_ready = m_ready;
        post_busy  = m_busy;
    endtask

    // Value of slot s if txd held steady for all CPB cycles of it, otherwise x.
    function automatic logic slot_val(input int s);
        logic v;
        v = cap_txd[s*CPB];
        for (int c = 1; c < CPB; c++)
            if (cap_txd[s*CPB+c] !== v) return 1'bx;
        return v;
    endfunction

    function automatic int tick_count(input int n);
        int t = 0;
        for (int i = 0; i < n; i++) if (cap_tick[i] === 1'b1) t++;
        return t;
    endfunction

    function automatic int busy_count(input int n);
        int b = 0;
        for (int i = 0; i < n; i++) if (cap_busy[i] === 1'b1) b++;
        return b;
    endfunction

    task automatic test_reset();
        sel = 2'd0;
        vectors++; if (m_txd !== 1'b1) begin $display("FAIL reset_txd got %b want 1", m_txd); miscompares++; end
        vectors++; if (m_busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", m_busy); miscompares++; end
        vectors++; if (m_tick !== 1'b0) begin $display("FAIL reset_tick got %b want 0", m_tick); miscompares++; end
        vectors++; if (m_ready !== 1'b0) begin $display("FAIL reset_ready_in_rst got %b want 0", m_ready); miscompares++; end
        rst = 1'b0;
        step();
        vectors++; if (m_ready !== 1'b1) begin $display("FAIL reset_ready_after got %b want 1", m_ready); miscompares++; end
        vectors++; if (m_txd !== 1'b1) begin $display("FAIL reset_idle_txd got %b want 1", m_txd); miscompares++; end
    endtask

    task automatic test_basic();
        bit ok;
        logic [9:0] exp;
        exp = 10'b1010101010;
        launch(2'd0, 8'h55, 1'b0, ok);
        vectors++; if (!ok) begin $display("FAIL basic_handshake got timeout want ready"); miscompares++; end
        capture(40);
        for (int s = 0; s < 10; s++) begin
            vectors++;
            if (slot_val(s) !== exp[s]) begin
                $display("FAIL basic_slot%0d got %b want %b", s, slot_val(s), exp[s]); miscompares++;
            end
        end
        vectors++; if (tick_count(40) != 10) begin $display("FAIL basic_ticks got %0d want 10", tick_count(40)); miscompares++; end
        vectors++;
        if (cap_tick[0] !== 1'b0 || cap_tick[3] !== 1'b1 || cap_tick[39] !== 1'b1) begin
            $display("FAIL basic_tick_pos got %b%b%b want 011", cap_tick[0], cap_tick[3], cap_tick[39]); miscompares++;
        end
        vectors++;
        if (busy_count(40) != 40 || post_busy !== 1'b0) begin
            $display("FAIL basic_length got %0d busy,post %b want 40,0", busy_count(40), post_busy); miscompares++;
        end
        vectors++; if (post_ready !== 1'b1) begin $display("FAIL basic_ready_after got %b want 1", post_ready); miscompares++; end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [9:0] exp_a, exp_b;
        exp_a = 10'b1101001010;
        exp_b = 10'b1001111000;
        launch(2'd0, 8'hA5, 1'b1, ok);
        vectors++; if (!ok) begin $display("FAIL b2b_handshake got timeout want ready"); miscompares++; end
        tx_data = 8'h3C;
        capture(40);
        for (int s = 0; s < 10; s++) begin
            vectors++;
            if (slot_val(s) !== exp_a[s]) begin
                $display("FAIL b2b_a_slot%0d got %b want %b", s, slot_val(s), exp_a[s]); miscompares++;
            end
        end
        vectors++; if (busy_count(40) != 40) begin $display("FAIL b2b_a_length got %0d want 40", busy_count(40)); miscompares++; end
        vectors++;
        if (post_txd !== 1'b1 || post_busy !== 1'b0 || post_ready !== 1'b1) begin
            $display("FAIL b2b_gap got txd%b busy%b ready%b want 1 0 1", post_txd, post_busy, post_ready); miscompares++;
        end
        step();
        valid[0] = 1'b0;
        capture(40);
        for (int s = 0; s < 10; s++) begin
            vectors++;
            if (slot_val(s) !== exp_b[s]) begin
                $display("FAIL b2b_b_slot%0d got %b want %b", s, slot_val(s), exp_b[s]); miscompares++;
            end
        end
        vectors++; if (busy_count(40) != 40) begin $display("FAIL b2b_b_length got %0d want 40", busy_count(40)); miscompares++; end
        vectors++; if (post_ready !== 1'b1) begin $display("FAIL b2b_b_ready got %b want 1", post_ready); miscompares++; end
    endtask

    task automatic test_parity(input logic [1:0] s_inst, input logic [10:0] exp, input string nm);
        bit ok;
        launch(s_inst, 8'h07, 1'b0, ok);
        vectors++; if (!ok) begin $display("FAIL %s_handshake got timeout want ready", nm); miscompares++; end
        capture(44);
        for (int s = 0; s < 11; s++) begin
            vectors++;
            if (slot_val(s) !== exp[s]) begin
                $display("FAIL %s_slot%0d got %b want %b", nm, s, slot_val(s), exp[s]); miscompares++;
            end
        end
        vectors++; if (tick_count(44) != 11) begin $display("FAIL %s_ticks got %0d want 11", nm, tick_count(44)); miscompares++; end
        vectors++;
        if (busy_count(44) != 44 || post_busy !== 1'b0) begin
            $display("FAIL %s_length got %0d busy,post %b want 44,0", nm, busy_count(44), post_busy); miscompares++;
        end
    endtask

    task automatic test_two_stop();
        bit ok;
        logic [10:0] exp;
        exp = 11'b11000000000;
        launch(2'd3, 8'h00, 1'b0, ok);
        vectors++; if (!ok) begin $display("FAIL stop2_handshake got timeout want ready"); miscompares++; end
        capture(44);
        for (int s = 0; s < 11; s++) begin
            vectors++;
            if (slot_val(s) !== exp[s]) begin
                $display("FAIL stop2_slot%0d got %b want %b", s, slot_val(s), exp[s]); miscompares++;
            end
        end
        vectors++; if (tick_count(44) != 11) begin $display("FAIL stop2_ticks got %0d want 11", tick_count(44)); miscompares++; end
        vectors++;
        if (busy_count(44) != 44 || post_busy !== 1'b0 || post_ready !== 1'b1) begin
            $display("FAIL stop2_length got %0d busy,post %b ready %b want 44,0,1", busy_count(44), post_busy, post_ready);
            miscompares++;
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit bad;
        logic [9:0] exp;
        exp = 10'b1111111110;
        launch(2'd0, 8'hC3, 1'b0, ok);
        vectors++; if (!ok) begin $display("FAIL midrst_handshake got timeout want ready"); miscompares++; end
        for (int i = 0; i < 16; i++) step();
        rst = 1'b1;
        step();
        vectors++;
        if (m_txd !== 1'b1 || m_busy !== 1'b0 || m_tick !== 1'b0) begin
            $display("FAIL midrst_abort got txd%b busy%b tick%b want 1 0 0", m_txd, m_busy, m_tick); miscompares++;
        end
        vectors++; if (m_ready !== 1'b0) begin $display("FAIL midrst_ready_in_rst got %b want 0", m_ready); miscompares++; end
        rst = 1'b0;
        step();
        vectors++; if (m_ready !== 1'b1) begin $display("FAIL midrst_ready_after got %b want 1", m_ready); miscompares++; end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_txd !== 1'b1 || m_busy !== 1'b0) bad = 1'b1;
            step();
        end
        vectors++; if (bad) begin $display("FAIL midrst_no_resume got activity want idle line"); miscompares++; end
        launch(2'd0, 8'hFF, 1'b0, ok);
        vectors++; if (!ok) begin $display("FAIL midrst_ff_handshake got timeout want ready"); miscompares++; end
        capture(40);
        for (int s = 0; s < 10; s++) begin
            vectors++;
            if (slot_val(s) !== exp[s]) begin
                $display("FAIL midrst_ff_slot%0d got %b want %b", s, slot_val(s), exp[s]); miscompares++;
            end
        end
        vectors++; if (tick_count(40) != 10) begin $display("FAIL midrst_ff_ticks got %0d want 10", tick_count(40)); miscompares++; end
    endtask

    task automatic test_data_change();
        bit ok;
        logic [9:0] exp;
        exp = 10'b1111100000;
        launch(2'd0, 8'hF0, 1'b0, ok);
        vectors++; if (!ok) begin $display("FAIL datachg_handshake got timeout want ready"); miscompares++; end
        tx_data = 8'h00;
        capture(40);
        for (int s = 0; s < 10; s++) begin
            vectors++;
            if (slot_val(s) !== exp[s]) begin
                $display("FAIL datachg_slot%0d got %b want %b", s, slot_val(s), exp[s]); miscompares++;
            end
        end
    endtask

    task automatic test_handshake_in_reset();
        bit bad;
        sel      = 2'd0;
        tx_data  = 8'h00;
        rst      = 1'b1;
        valid[0] = 1'b1;
        step();
        rst      = 1'b0;
        valid[0] = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (m_txd !== 1'b1 || m_busy !== 1'b0) bad = 1'b1;
            step();
        end
        vectors++; if (bad) begin $display("FAIL rst_handshake got frame started want discarded"); miscompares++; end
        vectors++; if (m_ready !== 1'b1) begin $display("FAIL rst_handshake_ready got %b want 1", m_ready); miscompares++; end
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 4'b0000;
        tx_data = 8'h00;
        sel     = 2'd0;
        step();
        step();
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity(2'd1, 11'b11000001110, "par_even");
        test_parity(2'd2, 11'b10000001110, "par_odd");
        test_two_stop();
        test_reset_midframe();
        test_data_change();
        test_handshake_in_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200us");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 16. Clock cycles per serial bit; legal range 2 to 65535.
- REQ-002: Parameter DATA_BITS, default 8. Data bits per frame; legal range 5 to 8.
- REQ-003: Parameter PARITY_EN, default 0. When 1, a parity bit is inserted after the data bits.
- REQ-004: Parameter PARITY_ODD, default 0. Parity type: 0 = even, 1 = odd. Ignored when PARITY_EN=0.
- REQ-005: Parameter STOP_BITS, default 1. Number of stop bits; legal values 1 and 2.
- REQ-006: clk  input  1  Single clock; all logic is on its rising edge.
- REQ-007: rst  input  1  Reset, synchronous and active-high.
- REQ-008: tx_data  input  DATA_BITS  Byte to transmit; sampled only on handshake.
- REQ-009: tx_valid  input  1  Upstream offers tx_data.
- REQ-010: tx_ready  output  1  Block can accept a byte this cycle.
- REQ-011: txd  output  1  Serial line, registered; idles high.
- REQ-012: bit_tick  output  1  One-cycle pulse in the final clk cycle of each transmitted bit period.
- REQ-013: tx_busy  output  1  High while a frame is on the line, from start bit through last stop bit.

Function
- REQ-014: FSM states are IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when PARITY_EN=1.
- REQ-015: tx_ready = 1 in IDLE only, combinationally from state; 0 in all other states.
- REQ-016: Handshake: when tx_valid && tx_ready, tx_data is captured into a shift register and the FSM enters START on the next edge.
- REQ-017: Changes on tx_data after capture do not affect the frame in progress.
- REQ-018: tx_valid without tx_ready is ignored. Upstream holds tx_valid and tx_data until tx_ready.
- REQ-019: Latency: after a handshake at edge N, txd = 0 (start bit) from edge N+1.
- REQ-020: Every bit (start, data, parity, each stop) holds txd for exactly CLKS_PER_BIT cycles.
- REQ-021: Bit-period counter width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
- REQ-022: bit_tick = 1 when the counter equals CLKS_PER_BIT-1 in START, DATA, PARITY or STOP; 0 in IDLE.
- REQ-023: Data bits are sent LSB first; a data-bit index counts 0..DATA_BITS-1.
- REQ-024: Parity bit = XOR of the DATA_BITS bits, inverted when PARITY_ODD=1.
- REQ-025: txd = 1 during STOP. After the final stop-bit tick the FSM returns to IDLE.
- REQ-026: IDLE lasts at least 1 cycle between frames with txd = 1, so back-to-back frames have a 1-cycle gap.
- REQ-027: Frame length from first start-bit cycle to last stop-bit cycle = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
- REQ-028: tx_busy = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- REQ-029: bit_tick count per frame = 1+DATA_BITS+PARITY_EN+STOP_BITS.

Reset
- REQ-030: While rst=1 at an edge: state=IDLE, txd=1, bit_tick=0, tx_busy=0, counters=0, shift register=0.
- REQ-031: tx_ready = 0 while rst is asserted and 1 from the first edge after rst deasserts.
- REQ-032: Reset mid-frame aborts the frame. txd is 1 on the next edge and no partial bits resume after release.
- REQ-033: A handshake in the same cycle as rst=1 is discarded.

Verification (CLKS_PER_BIT=4, DATA_BITS=8 unless stated)
- REQ-034: Send 0x55, no parity, STOP_BITS=1.
  - txd per 4-cycle slot: 0,1,0,1,0,1,0,1,0,1.
  - Exactly 10 bit_ticks; frame length 40 cycles.
  - tx_ready high 1 cycle after the last tick.
- REQ-035: Back-to-back 0xA5 then 0x3C with tx_valid held high.
  - Two 40-cycle frames separated by exactly one txd=1 idle cycle.
  - Data bits LSB first: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- REQ-036: PARITY_EN=1, PARITY_ODD=0, send 0x07.
  - Parity slot = 1; 11 bit_ticks; 44 cycles.
  - Repeat with PARITY_ODD=1: parity slot = 0.
- REQ-037: STOP_BITS=2, send 0x00.
  - 8 zero data slots, then txd=1 for 8 cycles.
  - 11 bit_ticks; 44 cycles.
- REQ-038: Assert rst for 1 cycle at cycle 17 of a frame.
  - Next edge: txd=1, tx_busy=0, bit_tick=0.
  - tx_ready=1 one edge after rst release.
  - A new byte 0xFF then transmits a complete, correct frame.
- REQ-039: Change tx_data to 0x00 on the cycle after accepting 0xF0.
  - Transmitted data slots: 0,0,0,0,1,1,1,1.
